// File: rtl/rv32i_types.sv
// Shared RV32I types: register index, data word and architectural register count.
package rv32i_types;

  typedef logic [4:0]  rv32i_reg;
  typedef logic [31:0] rv32i_word;

  localparam int NUM_REGS = 32;

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register.
// Saturates at both ends and reports the offending event on err.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             issue,
  input  logic             write,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_nxt;

  // An issue and a write landing together cancel out, so neither can err.
  always_comb begin
    count_nxt = count;
    err       = 1'b0;
    if (issue && !write) begin
      if (count == CNT_MAX) err = 1'b1;
      else                  count_nxt = count + 1'b1;
    end else if (write && !issue) begin
      if (count == '0) err = 1'b1;
      else             count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count <= '0;
    else if (!stall) count <= count_nxt;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with per-register pending-write scoreboard.
// Define REGFILE_WB_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard
  import rv32i_types::*;
#(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        wb_load,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rs1_out,
  output logic [31:0] rs2_out,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        sb_overflow
);

  rv32i_word        regs [NUM_REGS];
  logic [CNT_W-1:0] cnt  [NUM_REGS];
  logic [NUM_REGS-1:0] err;
  logic             wr_ev;
  logic             iss_ev;

  // Events are qualified here once so every consumer sees identical conditions.
  assign wr_ev  = wb_load     && !stall && !rst && (wb_rd    != 5'd0);
  assign iss_ev = issue_valid && !stall && !rst && (issue_rd != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ev) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign cnt[0] = '0;
  assign err[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .issue (iss_ev && (issue_rd == 5'(g))),
      .write (wr_ev  && (wb_rd    == 5'(g))),
      .count (cnt[g]),
      .err   (err[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sb_overflow <= 1'b0;
    else if (|err)  sb_overflow <= 1'b1;
  end

  always_comb begin
    rs1_out  = regs[rs1];
    rs1_busy = (cnt[rs1] != '0);
`ifdef REGFILE_WB_BYPASS_EN
    if (wr_ev && (wb_rd == rs1)) begin
      rs1_out = wb_data;
      if (cnt[rs1] == CNT_W'(1)) rs1_busy = 1'b0;
    end
`endif
    if (rst || (rs1 == 5'd0)) begin
      rs1_out  = '0;
      rs1_busy = 1'b0;
    end
  end

  always_comb begin
    rs2_out  = regs[rs2];
    rs2_busy = (cnt[rs2] != '0);
`ifdef REGFILE_WB_BYPASS_EN
    if (wr_ev && (wb_rd == rs2)) begin
      rs2_out = wb_data;
      if (cnt[rs2] == CNT_W'(1)) rs2_busy = 1'b0;
    end
`endif
    if (rst || (rs2 == 5'd0)) begin
      rs2_out  = '0;
      rs2_busy = 1'b0;
    end
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter: CNT_W, 2, width of each per-register pending-write counter (max in-flight writes per register = 2^CNT_W - 1).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: stall  input  1  pipeline stall; blocks every state update while high.
REQ-005 SHALL have port: wb_load  input  1  writeback-stage register-file write enable.
REQ-006 SHALL have port: wb_rd  input  5  writeback destination register index.
REQ-007 SHALL have port: wb_data  input  32  writeback data.
REQ-008 SHALL have port: issue_valid  input  1  decode issues an instruction that will write issue_rd.
REQ-009 SHALL have port: issue_rd  input  5  destination index of the issued instruction.
REQ-010 SHALL have port: rs1, rs2  input  5 each  decode-stage source read indices.
REQ-011 SHALL have port: rs1_out, rs2_out  output  32 each  source operand data.
REQ-012 SHALL have port: rs1_busy, rs2_busy  output  1 each  source has an outstanding write.
REQ-013 SHALL have port: sb_overflow  output  1  sticky error flag for counter overflow or underflow.

Function
REQ-014 SHALL hold 32 x 32-bit registers; x0 reads 0, is never written, and is never busy.
REQ-015 SHALL write wb_data to reg[wb_rd] at the clock edge when wb_load=1, stall=0 and wb_rd!=0.
REQ-016 SHALL produce rs1_out/rs2_out combinationally from register contents, with bypass per Configuration.
REQ-017 SHALL keep one CNT_W-bit pending counter per register; the write event is REQ-015's condition and the issue event is issue_valid=1, stall=0, issue_rd!=0.
REQ-018 SHALL update the counter by +1 on issue only, -1 on write only, and leave it unchanged when both events hit the same register in one cycle.
REQ-019 SHALL drive rsN_busy = (count[rsN] != 0), except that rsN_busy SHALL be 0 when a write event to rsN with count[rsN]==1 occurs in the same cycle and the bypass is compiled in.
REQ-020 SHALL, on issue to a register at max count, leave the count saturated and set sb_overflow.
REQ-021 SHALL, on a write to a register at count 0, leave the count at 0, still write the data, and set sb_overflow.
REQ-022 SHALL keep sb_overflow set until reset.
REQ-023 SHALL change no register contents, counters or flags while stall=1; outputs follow the current state combinationally.

Reset
REQ-024 SHALL, while rst=1 and independent of clk, clear all registers, all counters and sb_overflow to 0.
REQ-025 SHALL drive rsN_out=0 and rsN_busy=0 during reset.
REQ-026 SHALL discard any write or issue coincident with reset; the first update takes place on the first clock edge after rst falls.

Configuration
REQ-027 SHALL, with macro REGFILE_WB_BYPASS_EN defined, return wb_data on rsN_out when a write event targets rsN in the same cycle (write-through).
REQ-028 SHALL, without REGFILE_WB_BYPASS_EN, return only stored contents; the written value is visible the cycle after the write, and the REQ-019 busy exception does not apply.

Structure
REQ-029 SHALL place in the shared rv32i_types package: rv32i_reg (5-bit) and rv32i_word (32-bit), plus the constant for register count (32).
REQ-030 SHALL implement the per-register counter logic in one sub-module, sb_counter, instantiated 31 times (x1..x31).

Verification
REQ-031 SHALL check: reset, then write x5=0xDEADBEEF; read rs1=5 next cycle -> 0xDEADBEEF, rs1_busy=0.
REQ-032 SHALL check: issue x7 twice, then one write 0x11 to x7 -> rs1_busy=1 (count 1); second write 0x22 -> rs1_busy=0, rs1_out=0x22.
REQ-033 SHALL check, with the bypass compiled in: write x3=0x1234 while rs2=3 in the same cycle -> rs2_out=0x1234 combinationally; without the bypass -> old value, then 0x1234 next cycle.
REQ-034 SHALL check: same-cycle issue x9 and write x9 at count 1 -> count stays 1, rs1_busy=1; write of 0xFFFFFFFF to x0 -> rs1=0 reads 0.
REQ-035 SHALL check: stall=1 with a write to x4 and an issue to x4 -> no change; issuing x6 four times with CNT_W=2 -> sb_overflow=1 and count stays 3.
REQ-036 SHALL check: assert rst mid-cycle with x1 pending -> all counters, registers and sb_overflow are 0 immediately.
